// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the registered 1-to-LANES demux
//
// Purpose : parameter limits, drop counter width and select-width helper used
//           by demux1ton_reg and demux_lane.
// Ports   : none (package).

package demux_pkg;

  // Supported lane count range for demux1ton_reg.
  localparam int LANES_MIN = 2;
  localparam int LANES_MAX = 16;

  // Width of the saturating out-of-range drop counter.
  localparam int DROP_CNT_W = 8;

  // Number of select bits needed to address `lanes` lanes. Clamped to at
  // least one bit so the select port never collapses to zero width.
  function automatic int sel_width(input int lanes);
    if (lanes <= 2) begin
      return 1;
    end
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - single-entry output register slot for one demux lane
//
// Purpose : holds one word plus a full flag; drains on valid && out_ready and
//           accepts a new word when empty or when draining in the same cycle.
// Ports   :
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   write d into the slot at this edge (only when can_accept)
//   d          in   N-bit word to store
//   out_ready  in   consumer ready for this lane
//   q          out  stored word (holds last value when empty)
//   valid      out  slot is full
//   can_accept out  slot can take a word this cycle

module demux_lane #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         can_accept
);

  // Pass-through replace: a full slot being drained this cycle frees room
  // for a new word at the same edge, giving one word per cycle per lane.
  assign can_accept = ~valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // A load wins over a concurrent drain: the slot stays full with the
      // new word.
      q     <= d;
      valid <= 1'b1;
    end else if (valid && out_ready) begin
      // Data is left untouched on drain; consumers qualify with valid.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1ton_reg.sv
// rtl/demux1ton_reg.sv - registered 1-to-LANES demultiplexer with per-lane handshake
//
// Purpose : steers one producer stream to one of LANES output registers, or
//           broadcasts to all of them; counts words dropped for an
//           out-of-range select.
// Ports   :
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   N-bit input word
//   in_sel     in   destination lane index
//   in_bcast   in   write all lanes, ignore in_sel
//   in_valid   in   input word present
//   in_ready   out  input accepted this cycle if in_valid
//   out_data   out  lane k at bits [k*N +: N]
//   out_valid  out  per-lane full flag
//   out_ready  in   per-lane consumer ready
//   drop_cnt   out  saturating count of out-of-range drops

module demux1ton_reg
  import demux_pkg::*;
#(
  parameter int N     = 9,
  parameter int LANES = 4,
  parameter int SEL_W = sel_width(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES*N-1:0]    out_data,
  output logic [LANES-1:0]      out_valid,
  input  logic [LANES-1:0]      out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_lanes_check
    $error("demux1ton_reg: LANES out of supported range");
  end

  logic [LANES-1:0] can_accept;
  logic [LANES-1:0] sel_hit;
  logic [LANES-1:0] load;
  logic             in_range;
  logic             transfer;
  logic             drop;

  // One extra bit so LANES itself is representable even when LANES is a
  // power of two (e.g. LANES=4 with a 2-bit select).
  assign in_range = ({1'b0, in_sel} < (SEL_W + 1)'(LANES));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sel_hit[k] = in_range && (in_sel == SEL_W'(k));

    demux_lane #(
      .N(N)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .d          (in_data),
      .out_ready  (out_ready[k]),
      .q          (out_data[k*N +: N]),
      .valid      (out_valid[k]),
      .can_accept (can_accept[k])
    );
  end

  // Broadcast is all-or-nothing, so it waits until every lane can accept.
  // An out-of-range unicast is always accepted and discarded.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &can_accept;
    end else if (in_range) begin
      in_ready = |(sel_hit & can_accept);
    end
  end

  assign transfer = in_valid && in_ready;
  assign load     = {LANES{transfer}} & ({LANES{in_bcast}} | sel_hit);
  assign drop     = in_valid && !in_bcast && !in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/demux1ton_reg.md
# demux1toN_reg

Registered 1-to-LANES demultiplexer with a per-lane valid/ready handshake. It is the distribution counterpart of the mux2to1 used in the MACC multiplier datapath: one producer stream (multiplier or partial-sum results) is steered to one of LANES consumer lanes, or broadcast to all of them. Each lane has a single-entry output register, so backpressure is handled per lane and throughput is one word per cycle.

## Interface
- N, default 9: data width in bits.
- LANES, default 4: number of output lanes. Legal range is 2..16; LANES does not have to be a power of two.
- SEL_W, default $clog2(LANES): select width. Derived; never overridden.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N  input word.
- in_sel  in  SEL_W  destination lane index.
- in_bcast  in  1  when 1, write to all lanes and ignore in_sel.
- in_valid  in  1  input word present.
- in_ready  out  1  input can be accepted this cycle.
- out_data  out  LANES*N  lane k occupies bits [k*N +: N].
- out_valid  out  LANES  per-lane word present.
- out_ready  in  LANES  per-lane consumer ready.
- drop_cnt  out  8  saturating count of words dropped because in_sel was out of range.

## Operation
- Each lane holds one register entry: a data register plus a full flag. out_valid[k] is the full flag of lane k.
- A lane can accept a word when it is empty, or when it is full and out_ready[k]=1 in the same cycle (pass-through replace).
- Unicast (in_bcast=0, in_sel<LANES):
  - in_ready = accept(lane in_sel).
  - The transfer is in_valid && in_ready.
  - Only lane in_sel loads. Every other lane is unaffected.
- Broadcast (in_bcast=1):
  - in_ready = AND of accept(k) over all lanes.
  - On transfer, every lane loads in_data in the same cycle.
  - There is no partial broadcast.
- Out-of-range select (in_bcast=0, in_sel>=LANES):
  - in_ready=1.
  - On in_valid, the word is dropped and drop_cnt increments, saturating at 255.
  - No lane changes.
- A lane drains on out_valid[k] && out_ready[k]. If there is no reload in that cycle, the full flag clears.
- A simultaneous drain and load on the same lane leaves the lane full, holding the new word.
- out_data of an empty lane holds its last value. Consumers must qualify it with out_valid.
- in_data, in_sel and in_bcast are sampled only on a transfer edge. There is no requirement for them to be stable while in_ready=0.

## Timing
- Latency is 1 cycle: a word accepted at edge t is visible on out_data/out_valid after edge t.
- in_ready is combinational from in_sel, in_bcast, the lane full flags and out_ready. There is no combinational path from in_data.
- out_valid and out_data are registered outputs. out_ready does not feed any output combinationally except in_ready.
- Throughput is 1 word/cycle to any lane whose consumer holds out_ready=1.
- Reset (asynchronous assert, any time including mid-transfer):
  - All full flags go to 0, so out_valid=0.
  - out_data goes to 0 and drop_cnt goes to 0.
  - in_ready reflects the empty state (1) while rst is high.
  - An in-flight word is lost.
- Reset deassertion is synchronised by the integrator. The first transfer can happen at the first edge after release.

## Structure
- The package demux_pkg holds:
  - the function sel_width(lanes);
  - the constant DROP_CNT_W=8;
  - the localparam limits LANES_MIN=2 and LANES_MAX=16.
- Sub-module demux_lane (parameter N) implements one lane slot:
  - ports clk, rst, load, d, out_ready, q, valid, can_accept;
  - instantiated LANES times in a generate loop.
- The top level holds the select decode, the broadcast AND-reduction, in_ready generation and the drop counter.

## Test plan
- Reset, then unicast: N=9, LANES=4, in_sel=2, in_data=9'h155, in_valid=1, out_ready=4'b1111 → after 1 edge out_valid=4'b0100 and lane 2 data=9'h155; the next cycle out_valid=0 with no new input.
- Backpressure: lane 1 full, out_ready[1]=0, in_sel=1 → in_ready=0 and lane 1 keeps its old word. Setting out_ready[1]=1 in the same cycle → in_ready=1, and the new word replaces the old one with out_valid[1] staying 1.
- Broadcast: in_bcast=1, in_data=9'h0AA, lane 3 full with out_ready[3]=0 → in_ready=0 and no lane loads. Once lane 3 drains → all four lanes load 9'h0AA together and out_valid=4'b1111.
- Out-of-range: LANES=3, in_sel=3, in_valid=1 held for 300 cycles → out_valid stays 0, in_ready=1, and drop_cnt saturates at 255.
- Streaming: words 1..8 with in_sel cycling 0,1,2,3 and out_ready all 1 → one word/cycle, each lane sees its words in order, no bubbles.
- Mid-operation reset: assert rst asynchronously between edges while lanes 0 and 2 are full → out_valid=0, out_data=0 and drop_cnt=0 immediately, without waiting for a clock edge.
